// File: rtl/mem_stage_aligned.sv
// Memory pipeline stage: sized, alignment-checked loads/stores to a word-organised
// RAM with a fixed access latency, a registered result and a combinational debug port.
module mem_stage_aligned #(
    parameter int TAM_DATA    = 32,
    parameter int NUM_DIREC   = 7,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_rd_mem,
    input  logic                  i_wr_mem,
    input  logic                  i_is_unsigned,
    input  logic                  i_mem_to_reg,
    input  logic [1:0]            i_size,
    input  logic [TAM_DATA-1:0]   i_addr,
    input  logic [TAM_DATA-1:0]   i_data,
    input  logic [NUM_DIREC-1:0]  i_debug_pointer,
    output logic [TAM_DATA-1:0]   o_debug_read,
    output logic [TAM_DATA-1:0]   o_data,
    output logic                  o_valid,
    output logic                  o_stall,
    output logic                  o_misaligned
);

    localparam int NUM_BYTES = TAM_DATA / 8;
    localparam int OFF       = $clog2(NUM_BYTES);
    localparam int DEPTH     = 1 << NUM_DIREC;
    localparam logic [2:0] LAT = MEM_LATENCY[2:0];

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d, wr_q, wr_d, uns_q, uns_d, m2r_q, m2r_d;
    logic [1:0]            size_q, size_d;
    logic [TAM_DATA-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [TAM_DATA-1:0]   o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d, o_mis_q, o_mis_d;
    logic [TAM_DATA-1:0]   mem_q [DEPTH];

    logic                  cur_rd, cur_wr, cur_uns, cur_m2r;
    logic [1:0]            cur_size;
    logic [TAM_DATA-1:0]   cur_addr, cur_wdata;
    logic [NUM_DIREC-1:0]  cur_idx;
    logic [OFF+2:0]        sh;
    logic [TAM_DATA-1:0]   size_mask, lane_mask, rd_word, shifted, load_data, wr_word;
    logic                  sign_bit, aligned, mem_op, do_access, stall;

    // In IDLE the live inputs drive the datapath; in BUSY the latched request does.
    always_comb begin
        if (state_q == IDLE) begin
            cur_rd    = i_rd_mem;
            cur_wr    = i_wr_mem;
            cur_uns   = i_is_unsigned;
            cur_m2r   = i_mem_to_reg;
            cur_size  = i_size;
            cur_addr  = i_addr;
            cur_wdata = i_data;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_uns   = uns_q;
            cur_m2r   = m2r_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        cur_idx = cur_addr[NUM_DIREC+OFF-1:OFF];
        sh      = {cur_addr[OFF-1:0], 3'b000};
        mem_op  = cur_rd | cur_wr;

        case (cur_size)
            2'b00:   size_mask = TAM_DATA'(8'hFF);
            2'b01:   size_mask = TAM_DATA'(16'hFFFF);
            2'b10:   size_mask = TAM_DATA'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase

        case (cur_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~cur_addr[0];
            2'b10:   aligned = (cur_addr[1:0] == 2'b00);
            default: aligned = (cur_addr[OFF-1:0] == '0);
        endcase

        rd_word   = mem_q[cur_idx];
        shifted   = rd_word >> sh;
        case (cur_size)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            default: sign_bit = shifted[31];
        endcase
        // Full-width mask is all ones, so the fill term vanishes for full loads.
        load_data = (shifted & size_mask) |
                    ({TAM_DATA{sign_bit & ~cur_uns}} & ~size_mask);

        lane_mask = size_mask << sh;
        wr_word   = (rd_word & ~lane_mask) | ((cur_wdata << sh) & lane_mask);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        uns_d     = uns_q;
        m2r_d     = m2r_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_mis_d   = 1'b0;
        do_access = 1'b0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (mem_op && aligned) begin
                        if (MEM_LATENCY == 0) begin
                            do_access = 1'b1;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = 3'd1;
                            stall   = 1'b1;
                            rd_d    = i_rd_mem;
                            wr_d    = i_wr_mem;
                            uns_d   = i_is_unsigned;
                            m2r_d   = i_mem_to_reg;
                            size_d  = i_size;
                            addr_d  = i_addr;
                            wdata_d = i_data;
                        end
                    end else begin
                        o_valid_d = 1'b1;
                        o_mis_d   = mem_op;
                        o_data_d  = (mem_op || i_mem_to_reg) ? '0 : i_addr;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == LAT) begin
                    do_access = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            o_valid_d = 1'b1;
            o_data_d  = (cur_rd && !cur_wr && cur_m2r) ? load_data : cur_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            m2r_q     <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_mis_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            uns_q     <= uns_d;
            m2r_q     <= m2r_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_mis_q   <= o_mis_d;
            if (do_access && cur_wr) begin
                mem_q[cur_idx] <= wr_word;
            end
        end
    end

    assign o_debug_read = mem_q[i_debug_pointer];
    assign o_data       = o_data_q;
    assign o_valid      = o_valid_q;
    assign o_misaligned = o_mis_q;
    assign o_stall      = stall & ~i_reset;

endmodule

// File: tb/tb_mem_stage_aligned.sv
// Directed bench: 32-bit/latency-2 instance for timing, lanes and reset abort,
// plus a 64-bit/latency-0 instance for wide accesses.
module tb_mem_stage_aligned;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst;
    logic        v, rd, wr, uns, m2r;
    logic [1:0]  sz;
    logic [31:0] addr, data, dbg_rd, od;
    logic [6:0]  dbg;
    logic        ov, ost, omis;

    logic        v6, rd6, wr6, uns6, m2r6;
    logic [1:0]  sz6;
    logic [63:0] addr6, data6, dbg_rd6, od6;
    logic [6:0]  dbg6;
    logic        ov6, ost6, omis6;

    mem_stage_aligned #(.TAM_DATA(32), .NUM_DIREC(7), .MEM_LATENCY(2)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_valid(v), .i_rd_mem(rd), .i_wr_mem(wr),
        .i_is_unsigned(uns), .i_mem_to_reg(m2r), .i_size(sz), .i_addr(addr),
        .i_data(data), .i_debug_pointer(dbg), .o_debug_read(dbg_rd),
        .o_data(od), .o_valid(ov), .o_stall(ost), .o_misaligned(omis)
    );

    mem_stage_aligned #(.TAM_DATA(64), .NUM_DIREC(7), .MEM_LATENCY(0)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_valid(v6), .i_rd_mem(rd6), .i_wr_mem(wr6),
        .i_is_unsigned(uns6), .i_mem_to_reg(m2r6), .i_size(sz6), .i_addr(addr6),
        .i_data(data6), .i_debug_pointer(dbg6), .o_debug_read(dbg_rd6),
        .o_data(od6), .o_valid(ov6), .o_stall(ost6), .o_misaligned(omis6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in the current cycle, then follows it to completion.
    // exp_cycles is the cycle index (accept = 0) at which o_valid must pulse.
    task automatic run32(input string tag, input logic r, input logic w, input logic u,
                         input logic m, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input int exp_cycles,
                         input logic [31:0] exp_data, input logic exp_mis);
        int cyc;
        v = 1'b1; rd = r; wr = w; uns = u; m2r = m; sz = s; addr = a; data = d;
        #1;
        chk({tag, ".stall0"}, 64'(ost), 64'(exp_cycles > 1));
        tick();
        v = 1'b0;
        cyc = 1;
        while (!ov && cyc < 20) begin
            chk({tag, ".stall"}, 64'(ost), 64'(cyc < exp_cycles - 1));
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_cycles));
        chk({tag, ".data"}, 64'(od), 64'(exp_data));
        chk({tag, ".mis"}, 64'(omis), 64'(exp_mis));
        chk({tag, ".stall_done"}, 64'(ost), 64'd0);
    endtask

    task automatic run64(input string tag, input logic r, input logic w, input logic u,
                         input logic [1:0] s, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] exp_data);
        v6 = 1'b1; rd6 = r; wr6 = w; uns6 = u; m2r6 = 1'b1; sz6 = s; addr6 = a; data6 = d;
        #1;
        chk({tag, ".stall"}, 64'(ost6), 64'd0);
        tick();
        v6 = 1'b0;
        chk({tag, ".valid"}, 64'(ov6), 64'd1);
        chk({tag, ".data"}, od6, exp_data);
    endtask

    initial begin
        rst = 1'b1;
        v = 0; rd = 0; wr = 0; uns = 0; m2r = 0; sz = 0; addr = 0; data = 0; dbg = 0;
        v6 = 0; rd6 = 0; wr6 = 0; uns6 = 0; m2r6 = 0; sz6 = 0; addr6 = 0; data6 = 0; dbg6 = 0;
        tick();
        tick();
        rst = 1'b0;
        dbg = 7'd2;
        #1;
        chk("rst.valid", 64'(ov), 64'd0);
        chk("rst.data", 64'(od), 64'd0);
        chk("rst.mis", 64'(omis), 64'd0);
        chk("rst.stall", 64'(ost), 64'd0);
        chk("rst.mem", 64'(dbg_rd), 64'd0);

        run32("st_word", 0, 1, 0, 1, 2'b10, 32'h8, 32'hDEADBEEF, 3, 32'h8, 0);
        dbg = 7'd2; #1;
        chk("st_word.mem", 64'(dbg_rd), 64'hDEADBEEF);
        tick();
        chk("st_word.pulse", 64'(ov), 64'd0);

        run32("st_byte", 0, 1, 0, 1, 2'b00, 32'h9, 32'h00000055, 3, 32'h9, 0);
        #1;
        chk("st_byte.mem", 64'(dbg_rd), 64'hDEAD55EF);
        // Back-to-back: each following request is presented in the previous o_valid cycle.
        run32("ld_b_s9", 1, 0, 0, 1, 2'b00, 32'h9, 32'h0, 3, 32'h00000055, 0);
        run32("ld_h_sA", 1, 0, 0, 1, 2'b01, 32'hA, 32'h0, 3, 32'hFFFFDEAD, 0);
        run32("ld_h_uA", 1, 0, 1, 1, 2'b01, 32'hA, 32'h0, 3, 32'h0000DEAD, 0);
        run32("ld_b_s8", 1, 0, 0, 1, 2'b00, 32'h8, 32'h0, 3, 32'hFFFFFFEF, 0);
        run32("ld_b_uB", 1, 0, 1, 1, 2'b00, 32'hB, 32'h0, 3, 32'h000000DE, 0);
        run32("ld_w_8", 1, 0, 0, 1, 2'b10, 32'h8, 32'h0, 3, 32'hDEAD55EF, 0);
        run32("ld_noreg", 1, 0, 0, 0, 2'b10, 32'h8, 32'h0, 3, 32'h8, 0);

        run32("mis_ld_h3", 1, 0, 0, 1, 2'b01, 32'h3, 32'h0, 1, 32'h0, 1);
        run32("mis_st_w6", 0, 1, 0, 1, 2'b10, 32'h6, 32'hFFFFFFFF, 1, 32'h0, 1);
        dbg = 7'd1; #1;
        chk("mis.mem1", 64'(dbg_rd), 64'd0);
        dbg = 7'd0; #1;
        chk("mis.mem0", 64'(dbg_rd), 64'd0);
        dbg = 7'd2; #1;
        chk("mis.mem2", 64'(dbg_rd), 64'hDEAD55EF);

        run32("alu", 0, 0, 0, 0, 2'b10, 32'h1234, 32'h0, 1, 32'h00001234, 0);
        run32("alu_m2r", 0, 0, 0, 1, 2'b10, 32'h1234, 32'h0, 1, 32'h0, 0);

        tick();
        v = 1'b1; rd = 0; wr = 1; uns = 0; m2r = 1; sz = 2'b10; addr = 32'h10; data = 32'hFFFFFFFF;
        #1;
        chk("abort.stall0", 64'(ost), 64'd1);
        tick();
        v = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort.stall_rst", 64'(ost), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort.no_valid", 64'(ov), 64'd0);
            chk("abort.no_stall", 64'(ost), 64'd0);
            tick();
        end
        dbg = 7'd4; #1;
        chk("abort.mem4", 64'(dbg_rd), 64'd0);
        dbg = 7'd2; #1;
        chk("abort.mem2_cleared", 64'(dbg_rd), 64'd0);
        chk("abort.data", 64'(od), 64'd0);

        run32("st_after", 0, 1, 0, 1, 2'b10, 32'h10, 32'h12345678, 3, 32'h10, 0);
        dbg = 7'd4; #1;
        chk("st_after.mem4", 64'(dbg_rd), 64'h12345678);
        tick();

        run64("w64_st", 0, 1, 0, 2'b11, 64'h0, 64'h0123456789ABCDEF, 64'h0);
        dbg6 = 7'd0; #1;
        chk("w64.mem0", dbg_rd6, 64'h0123456789ABCDEF);
        run64("w64_ld_w4", 1, 0, 0, 2'b10, 64'h4, 64'h0, 64'h0000000001234567);
        run64("w64_ld_w0", 1, 0, 0, 2'b10, 64'h0, 64'h0, 64'hFFFFFFFF89ABCDEF);
        run64("w64_ld_b7", 1, 0, 1, 2'b00, 64'h7, 64'h0, 64'h0000000000000001);
        run64("w64_ld_full", 1, 0, 0, 2'b11, 64'h0, 64'h0, 64'h0123456789ABCDEF);
        tick();
        chk("w64.pulse", 64'(ov6), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_aligned.md
MEM_STAGE_ALIGNED -- requirements
Module: mem_stage_aligned

Interface
REQ-001 SHALL have parameter TAM_DATA, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_DIREC, default 7, word-address bits; depth 2^NUM_DIREC words of TAM_DATA.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, wait cycles per memory access; legal range 0..7.
REQ-004 SHALL have parameter-derived NUM_BYTES = TAM_DATA/8 and OFF = log2(NUM_BYTES), byte-offset bits.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  request present this cycle.
REQ-008 i_rd_mem / i_wr_mem  in  1 each  load / store request; both high is treated as a store.
REQ-009 i_is_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 i_mem_to_reg  in  1  o_data selects load result (1) or i_addr (0).
REQ-011 i_size  in  2  00 byte, 01 half, 10 32-bit word, 11 full TAM_DATA (same as 10 when TAM_DATA=32).
REQ-012 i_addr  in  TAM_DATA  byte address; word index = i_addr[NUM_DIREC+OFF-1:OFF]; upper bits ignored.
REQ-013 i_data  in  TAM_DATA  store data, right-justified.
REQ-014 i_debug_pointer  in  NUM_DIREC  debug word index.
REQ-015 o_debug_read  out  TAM_DATA  combinational read of word i_debug_pointer.
REQ-016 o_data  out  TAM_DATA  registered result.
REQ-017 o_valid  out  1  registered one-cycle completion pulse.
REQ-018 o_stall  out  1  combinational; upstream holds its outputs while high.
REQ-019 o_misaligned  out  1  registered; pulses with o_valid for a misaligned access.

Function
REQ-020 FSM states: IDLE, BUSY; request accepted only in IDLE when i_valid=1; i_valid ignored in BUSY.
REQ-021 Alignment: half needs addr[0]=0; 32-bit word needs addr[1:0]=0; full needs addr[OFF-1:0]=0; byte always aligned.
REQ-022 Non-memory request (rd=wr=0) or misaligned request: no memory access, no stall, o_valid=1 in cycle 1 (accept = cycle 0).
REQ-023 Non-memory completion: o_data = i_addr when i_mem_to_reg=0, else 0; misaligned completion: o_data=0, o_misaligned=1.
REQ-024 Aligned memory request: all inputs latched at accept (cycle 0); BUSY for cycles 1..MEM_LATENCY; o_valid=1 in cycle MEM_LATENCY+1.
REQ-025 o_stall=1 in cycles 0..MEM_LATENCY-1 of an aligned memory op, 0 otherwise; MEM_LATENCY=0 never stalls.
REQ-026 Store written at the edge ending cycle MEM_LATENCY; only lanes selected by size and offset change; byte lane = addr[OFF-1:0], half lanes start at 2*addr[OFF-1:1].
REQ-027 Load data = memory word read at the same edge; selected lanes shifted to bit 0, extended per i_is_unsigned to TAM_DATA; full-width load unmodified.
REQ-028 Load with i_mem_to_reg=0 returns latched i_addr; store completion returns o_data = latched i_addr.
REQ-029 A new request presented in the o_valid cycle is accepted (back-to-back, one memory op per MEM_LATENCY+1 cycles).
REQ-030 Debug read port is independent; reflects a store from the cycle after its write edge.

Reset
REQ-031 i_reset=1 at an edge: state IDLE, counter 0, o_data=0, o_valid=0, o_misaligned=0, all memory words 0.
REQ-032 Reset during BUSY aborts the op: no write occurs, no o_valid pulse; reset overrides a same-edge write.
REQ-033 o_stall=0 while i_reset=1.

Verification
REQ-034 MEM_LATENCY=2: store word 0xDEADBEEF @0x8 -> o_stall high cycles 0-1, o_valid cycle 3, o_debug_read[2]=0xDEADBEEF.
REQ-035 Then store byte 0x55 @0x9, load byte signed @0x9 and signed/unsigned half @0xA -> 0x00000055, 0xFFFFDEAD, 0x0000DEAD; debug[2]=0xDEAD55EF.
REQ-036 Load half @0x3 -> o_valid cycle 1, o_misaligned=1, o_data=0, o_stall never high, memory unchanged.
REQ-037 ALU pass-through i_addr=0x1234, rd=wr=0 -> o_data=0x00001234 in cycle 1, no stall.
REQ-038 Reset asserted in cycle 1 of store 0xFFFFFFFF @0x10 -> memory word 4 stays 0, no o_valid, o_stall=0.
REQ-039 TAM_DATA=64, MEM_LATENCY=0: store full 0x0123456789ABCDEF @0x0, load signed word @0x4 -> o_data=0x0000000001234567 cycle 1, no stall.
